axi_lite_apb_bridge: RTL and testbench

//  AXI4-Lite slave to APB4 master bridge: the block behind design_1_wrapper's pins.

---
 rtl/axi_lite_apb_bridge_pkg.sv | 19 +
 rtl/axi_lite_apb_bridge_if.sv | 67 ++++++
 rtl/axi_lite_apb_bridge.sv | 149 ++++++++++++++
 tb/tb_axi_lite_apb_bridge.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_apb_bridge_pkg.sv
// Shared types for the AXI4-Lite to APB4 bridge: FSM state encoding and AXI response codes.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    BRESP,
    RRESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] apb_resp(input logic slverr);
    return slverr ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_apb_bridge_if.sv
// AXI4-Lite and APB4 bundles; the bridge takes axi_lite_if.slave and drives apb_if.master.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/axi_lite_apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB4 master; accept to bvalid/rvalid is 3 cycles plus APB waits.
// Ready is only ever given in IDLE, so upstream is fully back-pressured while a transfer is in flight.
module axi_lite_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic        aclk,
  input logic        areset,
  axi_lite_if.slave  s_axi,
  apb_if.master      m_apb
);
  localparam int STRB_W = DATA_W / 8;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [2:0]        pprot_q, pprot_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;

  logic wr_elig, tie, grant_rd, grant_wr;
  logic awready_c, wready_c, arready_c;

  // A write needs both AW and W present; prio_q = 1 means the write wins the next tie.
  assign wr_elig  = s_axi.awvalid && s_axi.wvalid;
  assign tie      = wr_elig && s_axi.arvalid;
  assign grant_rd = s_axi.arvalid && (!wr_elig || !prio_q);
  assign grant_wr = wr_elig && (!s_axi.arvalid || prio_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      prio_q   <= 1'b0;
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      rdata_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      paddr_q  <= paddr_d;
      pprot_q  <= pprot_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    arready_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_rd) begin
          arready_c = 1'b1;
          paddr_d   = s_axi.araddr;
          pprot_d   = s_axi.arprot;
          pwrite_d  = 1'b0;
          pstrb_d   = '0;
          state_d   = SETUP;
        end else if (grant_wr) begin
          awready_c = 1'b1;
          wready_c  = 1'b1;
          paddr_d   = s_axi.awaddr;
          pprot_d   = s_axi.awprot;
          pwdata_d  = s_axi.wdata;
          pstrb_d   = s_axi.wstrb;
          pwrite_d  = 1'b1;
          state_d   = SETUP;
        end
        if (tie) begin
          prio_d = !prio_q;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (m_apb.pready) begin
          if (pwrite_q) begin
            bresp_d = apb_resp(m_apb.pslverr);
            state_d = BRESP;
          end else begin
            rresp_d = apb_resp(m_apb.pslverr);
            rdata_d = m_apb.prdata;
            state_d = RRESP;
          end
        end
      end
      BRESP: begin
        if (s_axi.bready) begin
          state_d = IDLE;
        end
      end
      RRESP: begin
        if (s_axi.rready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.arready = arready_c;
  assign s_axi.bvalid  = (state_q == BRESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = (state_q == RRESP);
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;

  // Control strobes decode straight from the state register so an async reset drops them at once.
  assign m_apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
  assign m_apb.penable = (state_q == ACCESS);
  assign m_apb.paddr   = paddr_q;
  assign m_apb.pprot   = pprot_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.pwdata  = pwdata_q;
  assign m_apb.pstrb   = pstrb_q;

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Bench for axi_lite_apb_bridge: transaction-level reference model checked every cycle, directed cases, random traffic.
module tb_axi_lite_apb_bridge;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  axi_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();
  apb_if      #(.ADDR_W(32), .DATA_W(32)) apb ();

  axi_lite_apb_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_axi  (axi.slave),
    .m_apb  (apb.master)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment configuration written by the main sequence
  bit          cfg_rand   = 1'b0;
  int          cfg_waits  = 0;
  int          cfg_rhold  = 0;
  logic [31:0] cfg_prdata = 32'h0;
  logic        cfg_slverr = 1'b0;

  // APB slave and AXI response-ready driver
  int acc_cnt = 0;
  int rsp_cnt = 0;
  initial begin
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;
    axi.bready  = 1'b0;
    axi.rready  = 1'b0;
    forever begin
      @(posedge aclk); #1;
      if (cfg_rand) begin
        apb.pready  = ($urandom_range(0, 2) != 0);
        apb.prdata  = $urandom;
        apb.pslverr = ($urandom_range(0, 3) == 0);
        axi.bready  = ($urandom_range(0, 1) == 1);
        axi.rready  = ($urandom_range(0, 1) == 1);
      end else begin
        apb.pready  = apb.penable && (acc_cnt >= cfg_waits);
        apb.prdata  = cfg_prdata;
        apb.pslverr = cfg_slverr;
        axi.bready  = axi.bvalid && (rsp_cnt >= cfg_rhold);
        axi.rready  = axi.rvalid && (rsp_cnt >= cfg_rhold);
      end
      acc_cnt = apb.penable ? acc_cnt + 1 : 0;
      rsp_cnt = (axi.bvalid || axi.rvalid) ? rsp_cnt + 1 : 0;
    end
  end

  // Reference model: one transfer in flight, tracked as "cycles since accept" and "APB done".
  bit          m_busy = 1'b0, m_done = 1'b0, m_wr = 1'b0, m_prio = 1'b0;
  int          m_t = 0;
  logic [31:0] m_addr, m_data, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;
  logic [1:0]  m_resp;
  bit          e_wr_el, e_tie, e_grd, e_gwr, e_sel, e_en;

  initial begin
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_prio = 1'b0;
        chk("rst_psel", apb.psel, 1'b0);
        chk("rst_penable", apb.penable, 1'b0);
        chk("rst_bvalid", axi.bvalid, 1'b0);
        chk("rst_rvalid", axi.rvalid, 1'b0);
      end else begin
        e_wr_el = axi.awvalid && axi.wvalid;
        e_tie   = e_wr_el && axi.arvalid;
        e_grd   = !m_busy && axi.arvalid && (!e_wr_el || !m_prio);
        e_gwr   = !m_busy && e_wr_el && (!axi.arvalid || m_prio);
        e_sel   = m_busy && !m_done;
        e_en    = e_sel && (m_t >= 2);
        chk("arready", axi.arready, e_grd);
        chk("awready", axi.awready, e_gwr);
        chk("wready", axi.wready, e_gwr);
        chk("psel", apb.psel, e_sel);
        chk("penable", apb.penable, e_en);
        chk("bvalid", axi.bvalid, m_busy && m_done && m_wr);
        chk("rvalid", axi.rvalid, m_busy && m_done && !m_wr);
        if (e_sel) begin
          chk("paddr", apb.paddr, m_addr);
          chk("pwrite", apb.pwrite, m_wr);
          chk("pprot", apb.pprot, m_prot);
          chk("pstrb", apb.pstrb, m_wr ? m_strb : 4'h0);
          if (m_wr) chk("pwdata", apb.pwdata, m_data);
        end
        if (m_busy && m_done && m_wr) chk("bresp", axi.bresp, m_resp);
        if (m_busy && m_done && !m_wr) begin
          chk("rresp", axi.rresp, m_resp);
          chk("rdata", axi.rdata, m_rdata);
        end
        // Advance to the state after the coming rising edge
        if (!m_busy) begin
          if (e_grd || e_gwr) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_t    = 1;
            m_wr   = e_gwr;
            m_addr = e_gwr ? axi.awaddr : axi.araddr;
            m_prot = e_gwr ? axi.awprot : axi.arprot;
            m_data = axi.wdata;
            m_strb = axi.wstrb;
            if (e_tie) m_prio = !m_prio;
          end
        end else if (!m_done) begin
          if (m_t >= 2 && apb.pready) begin
            m_done  = 1'b1;
            m_resp  = apb.pslverr ? 2'b10 : 2'b00;
            m_rdata = apb.prdata;
          end
          m_t++;
        end else if (m_wr ? axi.bready : axi.rready) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  // Drive requests and hold each valid until its handshake; returns handshake cycle numbers.
  task automatic axi_issue(input bit dw, input bit dr,
                           input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                           input logic [2:0] wp, input logic [31:0] ra, input logic [2:0] rp,
                           output int hs_w, output int hs_r);
    bit pend_w, pend_r, got_w, got_r;
    int budget;
    @(posedge aclk); #1;
    if (dw) begin
      axi.awaddr = wa; axi.awprot = wp; axi.wdata = wd; axi.wstrb = ws;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    end
    if (dr) begin
      axi.araddr = ra; axi.arprot = rp; axi.arvalid = 1'b1;
    end
    pend_w = dw; pend_r = dr; hs_w = -1; hs_r = -1; budget = 0;
    while ((pend_w || pend_r) && budget < 200) begin
      @(negedge aclk);
      budget++;
      got_w = pend_w && axi.awready;
      got_r = pend_r && axi.arready;
      if (got_w) hs_w = cyc;
      if (got_r) hs_r = cyc;
      @(posedge aclk); #1;
      if (got_w) begin axi.awvalid = 1'b0; axi.wvalid = 1'b0; pend_w = 1'b0; end
      if (got_r) begin axi.arvalid = 1'b0; pend_r = 1'b0; end
    end
    chk("handshake_timeout", {pend_w, pend_r}, 2'b00);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
  endtask

  task automatic wait_rsp(input bit wr, output int at);
    int budget;
    budget = 0;
    at = -1;
    while (budget < 200) begin
      @(negedge aclk);
      budget++;
      if (wr ? axi.bvalid : axi.rvalid) begin
        at = cyc;
        break;
      end
    end
    chk("response_timeout", (at < 0), 1'b0);
  endtask

  initial begin
    int hw, hr, tr, tb0, tx, budget;
    bit got;
    logic [31:0] a, d;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    areset = 1'b0;
    #2 areset = 1'b1;
    @(negedge aclk);
    chk("rst_paddr", apb.paddr, 32'h0);
    chk("rst_pwdata", apb.pwdata, 32'h0);
    chk("rst_pstrb", apb.pstrb, 4'h0);
    chk("rst_pprot", apb.pprot, 3'h0);
    chk("rst_pwrite", apb.pwrite, 1'b0);
    chk("rst_rdata", axi.rdata, 32'h0);
    chk("rst_bresp", axi.bresp, 2'b00);
    chk("rst_rresp", axi.rresp, 2'b00);
    chk("rst_awready", axi.awready, 1'b0);
    chk("rst_arready", axi.arready, 1'b0);
    @(posedge aclk); #1 areset = 1'b0;

    // Write 0x4 = 0xCAFEBABE, no wait states
    axi_issue(1, 0, 32'h4, 32'hCAFEBABE, 4'hF, 3'h0, 32'h0, 3'h0, hw, hr);
    @(negedge aclk);
    chk("wr_setup_psel", apb.psel, 1'b1);
    chk("wr_setup_penable", apb.penable, 1'b0);
    @(negedge aclk);
    chk("wr_access_penable", apb.penable, 1'b1);
    chk("wr_access_paddr", apb.paddr, 32'h4);
    chk("wr_access_pwrite", apb.pwrite, 1'b1);
    chk("wr_access_pwdata", apb.pwdata, 32'hCAFEBABE);
    chk("wr_access_pstrb", apb.pstrb, 4'hF);
    wait_rsp(1, tb0);
    chk("wr_bresp", axi.bresp, 2'b00);
    chk("wr_latency", tb0 - hw, 3);

    // Read 0x4 returning 0xDEADBEEF
    cfg_prdata = 32'hDEADBEEF;
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 3'h0, 32'h4, 3'h2, hw, hr);
    wait_rsp(0, tr);
    chk("rd_rdata", axi.rdata, 32'hDEADBEEF);
    chk("rd_rresp", axi.rresp, 2'b00);
    chk("rd_latency", tr - hr, 3);

    // Three wait states stretch ACCESS to four cycles
    cfg_waits = 3; cfg_prdata = 32'h0BAD_F00D;
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 3'h0, 32'h10, 3'h5, hw, hr);
    wait_rsp(0, tr);
    chk("wait_latency", tr - hr, 6);
    chk("wait_rdata", axi.rdata, 32'h0BAD_F00D);
    cfg_waits = 0;

    // Slave errors map to SLVERR
    cfg_slverr = 1'b1;
    axi_issue(1, 0, 32'h8, 32'h1111_2222, 4'h3, 3'h1, 32'h0, 3'h0, hw, hr);
    wait_rsp(1, tb0);
    chk("err_bresp", axi.bresp, 2'b10);
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 3'h0, 32'hC, 3'h0, hw, hr);
    wait_rsp(0, tr);
    chk("err_rresp", axi.rresp, 2'b10);
    cfg_slverr = 1'b0;

    // Tie from reset: read first, then write; bready held low 5 cycles
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    cfg_rhold = 5; cfg_prdata = 32'h5555_AAAA;
    axi_issue(1, 1, 32'h20, 32'h7777_8888, 4'hC, 3'h0, 32'h24, 3'h0, hw, hr);
    chk("tie_read_first", (hr >= 0) && (hw > hr), 1'b1);
    wait_rsp(1, tb0);
    @(posedge aclk); #1;
    axi.araddr = 32'h28; axi.arprot = 3'h0; axi.arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("hold_bvalid", axi.bvalid, 1'b1);
      chk("hold_no_arready", axi.arready, 1'b0);
    end
    budget = 0; got = 1'b0; tx = -1;
    while (!got && budget < 50) begin
      @(negedge aclk);
      budget++;
      if (axi.arready) begin got = 1'b1; tx = cyc; end
    end
    chk("hold_rd_accept_gap", tx - tb0, 6);
    @(posedge aclk); #1 axi.arvalid = 1'b0;
    wait_rsp(0, tr);
    chk("hold_rd_rdata", axi.rdata, 32'h5555_AAAA);
    cfg_rhold = 0;

    // Reset during ACCESS abandons the transfer
    cfg_waits = 10;
    axi_issue(1, 0, 32'h30, 32'h9999_0000, 4'hF, 3'h0, 32'h0, 3'h0, hw, hr);
    @(negedge aclk);
    @(negedge aclk);
    chk("pre_rst_penable", apb.penable, 1'b1);
    @(posedge aclk); #1 areset = 1'b1;
    #1;
    chk("midrst_psel", apb.psel, 1'b0);
    chk("midrst_penable", apb.penable, 1'b0);
    chk("midrst_bvalid", axi.bvalid, 1'b0);
    @(posedge aclk); #1 areset = 1'b0;
    cfg_waits = 0; cfg_prdata = 32'h1234_5678;
    axi_issue(0, 1, 32'h0, 32'h0, 4'h0, 3'h0, 32'h4, 3'h0, hw, hr);
    wait_rsp(0, tr);
    chk("post_rst_rdata", axi.rdata, 32'h1234_5678);
    chk("post_rst_rresp", axi.rresp, 2'b00);
    chk("post_rst_latency", tr - hr, 3);
    @(negedge aclk);

    // Random traffic against the model
    cfg_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom;
      axi_issue(kind != 1, kind != 0, a, d, 4'($urandom), 3'($urandom),
                $urandom, 3'($urandom), hw, hr);
      repeat ($urandom_range(0, 3)) @(posedge aclk);
    end
    repeat (60) @(posedge aclk);
    cfg_rand = 1'b0;
    repeat (20) @(posedge aclk);
    @(negedge aclk);
    chk("drain_idle", m_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
